// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch front end.
// A queue entry is packed as {pc, instr}: pc in the upper bits, instr in the lower.
package fetch_pkg;

  localparam int IFQ_DEPTH_DEFAULT = 4;
  localparam int PC_INCR           = 4;

  // Width of one packed {pc, instr} entry; the byte PC carries two extra bits.
  function automatic int ifq_entry_width(input int data_width, input int addr_width);
    return data_width + addr_width + 2;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of packed fetch entries with push/pop/flush and occupancy flags.
// The head entry is read combinationally so dispatch sees it one cycle after the push.
module ifq_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 41,
  parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             write_en;

  // Flush wins over any push in the same cycle.
  assign write_en = push & ~flush;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (write_en && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_next = count_reg + CNT_W'(1);
      else if (pop && !push) count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign rdata = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: drives the instruction RAM address, queues {pc, instr} pairs and
// hands them to dispatch in order; a redirect flushes the queue and restarts fetch.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = IFQ_DEPTH_DEFAULT,
  parameter int RESET_PC   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_WIDTH-1:0]      imem_addr,
  input  logic [DATA_WIDTH-1:0]      imem_q,
  input  logic                       jmp_valid,
  input  logic [ADDR_WIDTH+1:0]      jmp_pc,
  output logic                       dq_valid,
  input  logic                       dq_ready,
  output logic [DATA_WIDTH-1:0]      dq_instr,
  output logic [ADDR_WIDTH+1:0]      dq_pc,
  output logic                       fq_full,
  output logic                       fq_empty,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int PC_W    = ADDR_WIDTH + 2;
  localparam int ENTRY_W = ifq_entry_width(DATA_WIDTH, ADDR_WIDTH);
  localparam logic [PC_W-1:0] RESET_PC_V   = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] RESET_PC_ALN = {RESET_PC_V[PC_W-1:2], 2'b00};
  localparam logic [PC_W-1:0] WORD_MASK    = ~PC_W'(3);

  logic [PC_W-1:0]    fetch_pc_reg, fetch_pc_next;
  logic [ENTRY_W-1:0] head_entry;
  logic               push, pop;

  // Redirect kills the handshake so nothing is consumed from a queue being flushed.
  assign dq_valid = ~fq_empty & ~jmp_valid;
  assign pop      = dq_valid & dq_ready;
  assign push     = ~jmp_valid & (~fq_full | pop);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (jmp_valid)  fetch_pc_next = jmp_pc & WORD_MASK;
    else if (push)  fetch_pc_next = fetch_pc_reg + PC_W'(PC_INCR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_pc_reg <= RESET_PC_ALN;
    else     fetch_pc_reg <= fetch_pc_next;
  end

  assign imem_addr = fetch_pc_reg[PC_W-1:2];

  ifq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jmp_valid),
    .wdata ({fetch_pc_reg, imem_q}),
    .rdata (head_entry),
    .count (fq_count),
    .full  (fq_full),
    .empty (fq_empty)
  );

  assign dq_pc    = head_entry[ENTRY_W-1:DATA_WIDTH];
  assign dq_instr = head_entry[DATA_WIDTH-1:0];

endmodule
